// File: rtl/lsu_pkg.sv
// Shared size codes, FSM state type and counter-width helper for the LSU.
package lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic {IDLE, WAIT} lsu_state_t;

  // Width of the WAIT-cycle counter; at least one bit even with the timeout disabled.
  function automatic int cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a memory word and extends it to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then sign/zero extension by size code.
  always_comb begin
    byte_sel = raw[7:0];
    case (offset)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = offset[1] ? raw[31:16] : raw[15:0];
    case (size)
      LDST_B:  data = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data = {24'b0, byte_sel};
      LDST_H:  data = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data = {16'b0, half_sel};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit: core request -> memory transaction with byte enables,
// replicated store data, load alignment, stall generation and timeout.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int CNT_W = cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off_q;
  logic [2:0]       size_q;

  logic        legal, accept, in_wait, tout_hit, done, tout, req_act;
  logic [3:0]  be_raw;
  logic [31:0] wd_raw, load_data;

  // Alignment legality of the request as presented in IDLE.
  always_comb begin
    case (core_size_i)
      LDST_B, LDST_BU: legal = 1'b1;
      LDST_H, LDST_HU: legal = ~core_addr_i[0];
      LDST_W:          legal = (core_addr_i[1:0] == 2'b00);
      default:         legal = 1'b0;
    endcase
  end

  assign in_wait  = (state == WAIT);
  assign accept   = (state == IDLE) && core_req_i && legal;
  assign tout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  assign done     = in_wait && mem_ready_i;
  assign tout     = in_wait && !mem_ready_i && tout_hit;
  // Reset gates every output so nothing leaks out while rst_ni is low.
  assign req_act  = rst_ni && (accept || in_wait);

  // Byte enables and lane-replicated store data from the (held) core inputs.
  always_comb begin
    case (core_size_i)
      LDST_B, LDST_BU: begin
        be_raw = 4'b0001 << core_addr_i[1:0];
        wd_raw = {4{core_wd_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        be_raw = 4'b0011 << {core_addr_i[1], 1'b0};
        wd_raw = {2{core_wd_i[15:0]}};
      end
      default: begin
        be_raw = 4'b1111;
        wd_raw = core_wd_i;
      end
    endcase
  end

  lsu_load_align u_align (
    .offset (off_q),
    .size   (size_q),
    .raw    (mem_rd_i),
    .data   (load_data)
  );

  assign mem_req_o    = req_act;
  assign mem_we_o     = req_act && core_we_i;
  assign mem_be_o     = req_act ? be_raw : 4'b0000;
  assign mem_addr_o   = req_act ? core_addr_i : 32'b0;
  assign mem_wd_o     = req_act ? wd_raw : 32'b0;
  assign core_stall_o = rst_ni && (accept || (in_wait && !mem_ready_i && !tout_hit));
  assign err_o        = rst_ni && (((state == IDLE) && core_req_i && !legal) || tout);
  assign core_rd_o    = (rst_ni && done && !core_we_i) ? load_data : 32'b0;

  // FSM: accept in IDLE, count not-ready WAIT cycles, return on completion or timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      cnt    <= '0;
      off_q  <= 2'b00;
      size_q <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            state  <= WAIT;
            off_q  <= core_addr_i[1:0];
            size_q <= core_size_i;
          end
        end
        WAIT: begin
          if (done || tout) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Scoreboard bench for lsu_mem_if: random and directed load/store traffic
// against a word-array reference model, plus reset and no-timeout checks.
module tb_lsu_mem_if;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o, err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  // second instance with the timeout disabled
  logic        rst0_n, req0;
  logic [31:0] rd0, maddr0, mwd0;
  logic        stall0, err0, mreq0, mwe0;
  logic [3:0]  mbe0;

  always #5 clk = ~clk;

  lsu_mem_if #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .core_req_i(core_req_i), .core_we_i(core_we_i),
    .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
    .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
    .mem_ready_i(mem_ready_i)
  );

  lsu_mem_if #(.TIMEOUT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_ni(rst0_n), .core_req_i(req0), .core_we_i(1'b0),
    .core_size_i(3'b010), .core_addr_i(32'h10), .core_wd_i(32'h0),
    .core_rd_o(rd0), .core_stall_o(stall0), .err_o(err0),
    .mem_req_o(mreq0), .mem_we_o(mwe0), .mem_be_o(mbe0),
    .mem_addr_o(maddr0), .mem_wd_o(mwd0), .mem_rd_i(32'h0),
    .mem_ready_i(1'b0)
  );

  typedef struct {
    bit          legal;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] addr;
    logic [31:0] rd;
    bit          err;
    int          stalls;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem[16];
  logic [31:0] ref_mem[16];
  int          total = 0;
  int          bad = 0;
  int          stall_cnt = 0;
  bit          mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory environment: writes land on every sampled store request, reads return next cycle.
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem[mem_addr_o[5:2]][b*8 +: 8] <= mem_wd_o[b*8 +: 8];
      end else begin
        mem_rd_i <= mem[mem_addr_o[5:2]];
      end
    end
  end

  // Reference model: expected observable behaviour of one transaction.
  function automatic exp_t model(input bit we, input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] wd, input int delay);
    exp_t e;
    int off, idx;
    logic [31:0] word, sh;
    off = int'(addr % 4);
    idx = int'((addr / 4) % 16);
    e.we = we; e.addr = addr; e.rd = 0; e.err = 0; e.be = 0; e.wd = 0; e.stalls = 0;
    case (size)
      3'd0, 3'd4: e.legal = 1;
      3'd1, 3'd5: e.legal = (off % 2 == 0);
      3'd2:       e.legal = (off == 0);
      default:    e.legal = 0;
    endcase
    if (!e.legal) begin
      e.err = 1;
      return e;
    end
    case (size)
      3'd0, 3'd4: begin e.be = 4'(1 << off);          e.wd = (wd & 32'hFF) * 32'h01010101; end
      3'd1, 3'd5: begin e.be = (off >= 2) ? 4'hC : 4'h3; e.wd = (wd & 32'hFFFF) * 32'h00010001; end
      default:    begin e.be = 4'hF;                  e.wd = wd; end
    endcase
    if (delay >= TO) begin
      e.err = 1;
      e.stalls = TO;
    end else begin
      e.stalls = 1 + delay;
    end
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (e.be[b]) ref_mem[idx][b*8 +: 8] = e.wd[b*8 +: 8];
    end else if (!e.err) begin
      word = ref_mem[idx];
      sh = word >> (8 * off);
      case (size)
        3'd0: e.rd = {{24{sh[7]}}, sh[7:0]};
        3'd4: e.rd = sh & 32'hFF;
        3'd1: e.rd = {{16{sh[15]}}, sh[15:0]};
        3'd5: e.rd = sh & 32'hFFFF;
        default: e.rd = word;
      endcase
    end
    return e;
  endfunction

  // Driver: called at posedge+1, returns at posedge+1 with the request dropped.
  task automatic do_txn(input bit we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input int delay);
    exp_t e;
    bit fin;
    e = model(we, size, addr, wd, delay);
    q.push_back(e);
    core_req_i = 1; core_we_i = we; core_size_i = size; core_addr_i = addr; core_wd_i = wd;
    mem_ready_i = 0;
    @(posedge clk); #1;
    if (e.legal) begin
      fin = 0;
      for (int k = 0; k < 200 && !fin; k++) begin
        mem_ready_i = (k >= delay);
        @(negedge clk);
        if (!core_stall_o) fin = 1;
        @(posedge clk); #1;
      end
      if (!fin) begin
        total++; bad++;
        $display("FAIL txn_end: stall never dropped addr=%h", addr);
      end
    end
    core_req_i = 0; mem_ready_i = 0;
  endtask

  // Monitor: compares every active cycle against the head of the expectation queue.
  always @(negedge clk) begin
    if (mon_en && rst_ni) begin
      if (!core_req_i) begin
        check("idle_outputs", {mem_req_o, core_stall_o, err_o, core_rd_o != 0}, 4'b0000);
      end else if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL no_expectation: request with empty queue");
      end else begin
        check("mem_req", mem_req_o, q[0].legal);
        if (q[0].legal) begin
          check("mem_we", mem_we_o, q[0].we);
          check("mem_be", mem_be_o, q[0].be);
          check("mem_addr", mem_addr_o, q[0].addr);
          if (q[0].we) check("mem_wd", mem_wd_o, q[0].wd);
        end
        if (core_stall_o) begin
          stall_cnt++;
          check("rd_while_stalled", core_rd_o, 0);
          check("err_while_stalled", err_o, 0);
        end else begin
          check("err", err_o, q[0].err);
          check("core_rd", core_rd_o, q[0].rd);
          check("stall_cycles", stall_cnt, q[0].stalls);
          stall_cnt = 0;
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] v;
    logic [2:0]  sz;
    bit          ok;
    int          dly;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      if (i % 5 == 0) v = 32'hFA111EAF;
      if (i == 7) v = 32'hDEADBEEF;
      mem[i] = v; ref_mem[i] = v;
    end
    mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
    mem_rd_i = 0;
    rst_ni = 0; rst0_n = 0; req0 = 0;
    core_req_i = 1; core_we_i = 0; core_size_i = 3'b010; core_addr_i = 32'h10; core_wd_i = 0;
    mem_ready_i = 0;
    #3;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_stall", core_stall_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rd", core_rd_o, 0);
    core_req_i = 0;
    @(posedge clk); #1;
    rst_ni = 1; rst0_n = 1;
    @(posedge clk); #1;
    mon_en = 1;

    // directed cases from the block's worked examples
    do_txn(0, 3'b000, 32'h13, 0, 0);            // LB  -> FFFFFF88
    do_txn(0, 3'b101, 32'h12, 0, 0);            // LHU -> 00008899
    do_txn(0, 3'b001, 32'h10, 0, 2);            // LH  -> FFFFAABB
    do_txn(0, 3'b010, 32'h10, 0, 0);            // LW  -> 8899AABB
    do_txn(1, 3'b000, 32'h11, 32'h000000CC, 0); // SB
    do_txn(0, 3'b010, 32'h10, 0, 1);            // LW  -> 8899CCBB
    do_txn(0, 3'b010, 32'h16, 0, 0);            // misaligned
    do_txn(0, 3'b011, 32'h10, 0, 0);            // illegal size
    do_txn(0, 3'b010, 32'h10, 0, 40);           // timeout
    do_txn(0, 3'b010, 32'h14, 0, TO - 1);       // ready on last possible cycle
    do_txn(1, 3'b001, 32'h22, 32'h1234BEEF, TO);// store that times out

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 5: sz = 3'b000;
        1, 6: sz = 3'b001;
        2, 7: sz = 3'b010;
        3:    sz = 3'b100;
        4:    sz = 3'b101;
        8:    sz = 3'b011;
        default: sz = 3'($urandom_range(6, 7));
      endcase
      dly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
      do_txn((sz <= 3'b010) ? 1'($urandom_range(0, 1)) : 1'b0, sz,
             32'($urandom_range(0, 63)), $urandom, dly);
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
    end

    // reset pulled low mid-WAIT
    mon_en = 0;
    core_req_i = 1; core_we_i = 0; core_size_i = 3'b010; core_addr_i = 32'h10; mem_ready_i = 0;
    @(posedge clk); #1;
    check("wait_stall", core_stall_o, 1);
    #2 rst_ni = 0;
    #1;
    check("rst_wait_mem_req", mem_req_o, 0);
    check("rst_wait_stall", core_stall_o, 0);
    check("rst_wait_err", err_o, 0);
    core_req_i = 0;
    @(posedge clk); #1;
    rst_ni = 1;
    @(posedge clk); #1;
    mon_en = 1;
    do_txn(0, 3'b010, 32'h10, 0, 0);
    @(posedge clk); #1;

    // timeout disabled: stall holds indefinitely
    req0 = 1;
    @(posedge clk); #1;
    ok = 1;
    repeat (100) begin
      @(negedge clk);
      if (!stall0 || err0 || !mreq0) ok = 0;
    end
    check("no_timeout_hold", ok, 1);
    rst0_n = 0;
    #1;
    check("no_timeout_rst_stall", stall0, 0);
    req0 = 0;

    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
